// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// One operation in flight at a time: accept (IDLE), execute (EXEC), respond (RESP).
//
// state | meaning
// IDLE  | waiting for a request; ready follows the round-robin grant
// EXEC  | operands held on the ALU; result captured at the end of this cycle
// RESP  | one-cycle result strobe to the owning requester
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_left,
    input  logic [WIDTH-1:0] req0_right,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_left,
    input  logic [WIDTH-1:0] req1_right,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_left,
    output logic [WIDTH-1:0] alu_right,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q;
    logic             owner_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_left_q;
    logic [WIDTH-1:0] alu_right_q;
    logic [3:0]       alu_control_q;

    logic             any_req;
    logic             grant;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_left;
    logic [WIDTH-1:0] sel_right;
    logic             sel_legal;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // last_q holds the previous winner; on contention the other side wins
    assign any_req   = req0_valid | req1_valid;
    assign grant     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign accept    = (state_q == IDLE) && any_req;
    assign sel_op    = grant ? req1_op    : req0_op;
    assign sel_left  = grant ? req1_left  : req0_left;
    assign sel_right = grant ? req1_right : req0_right;
    assign sel_legal = op_legal(sel_op);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = accept && !grant;
        req1_ready  = accept && grant;
        busy        = (state_q == EXEC) || (state_q == RESP);
        rsp0_valid  = (state_q == RESP) && !owner_q;
        rsp1_valid  = (state_q == RESP) && owner_q;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp0_err    = rsp0_valid && err_q;
        rsp1_err    = rsp1_valid && err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            err_q         <= 1'b0;
            result_q      <= '0;
            alu_left_q    <= '0;
            alu_right_q   <= '0;
            alu_control_q <= 4'b0000;
        end else begin
            if (accept) begin
                last_q        <= grant;
                owner_q       <= grant;
                err_q         <= !sel_legal;
                alu_left_q    <= sel_left;
                alu_right_q   <= sel_right;
                alu_control_q <= sel_legal ? sel_op : 4'b0000;
            end
            // illegal opcodes still run the ALU as AND; the result is discarded
            if (state_q == EXEC) begin
                result_q <= err_q ? '0 : alu_out;
            end
        end
    end

    assign alu_left    = alu_left_q;
    assign alu_right   = alu_right_q;
    assign alu_control = alu_control_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level reference model with a
// per-cycle comparator, plus literal expectations on the directed vectors.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 4'd0, req1_op = 4'd0;
    logic [W-1:0] req0_left = '0, req0_right = '0, req1_left = '0, req1_right = '0;
    logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [W-1:0] rsp0_result, rsp1_result;
    logic [W-1:0] alu_left, alu_right, alu_out;
    logic [3:0]   alu_control;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_left(req0_left), .req0_right(req0_right),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_left(req1_left), .req1_right(req1_right),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_left(alu_left), .alu_right(alu_right), .alu_control(alu_control),
        .alu_out(alu_out), .busy(busy)
    );

    // {err, result} for an opcode applied to two operands
    function automatic logic [W:0] ref_op(input logic [3:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
        case (op)
            4'b0000: return {1'b0, l & r};
            4'b0001: return {1'b0, l | r};
            4'b0010: return {1'b0, l + r};
            4'b0110: return {1'b0, l - r};
            4'b0111: return {1'b0, (l < r) ? 32'd1 : 32'd0};
            4'b1100: return {1'b0, ~(l | r)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    logic [W:0] alu_full;
    assign alu_full = ref_op(alu_control, alu_left, alu_right);
    assign alu_out  = alu_full[W-1:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k counts edges; an accept on edge k makes the op busy for two
    // cycles, with the response strobe in the second.
    int           k = 0, m_free = 0, rsp_due = -1;
    bit           model_ok = 0, pend = 0, p_own = 0, p_err = 0, pref0 = 1;
    logic [W-1:0] p_res = '0, e_l = '0, e_r = '0;
    logic [3:0]   e_c = 4'd0;

    initial forever begin
        bit           idle_pre, g;
        logic [3:0]   op;
        logic [W-1:0] l, r;
        logic [W:0]   res;
        @(posedge clk);
        idle_pre = (k >= m_free);
        k = k + 1;
        if (!reset_n) begin
            model_ok = 1; pend = 0; m_free = k; pref0 = 1;
            e_l = '0; e_r = '0; e_c = 4'd0;
        end else if (model_ok && idle_pre && (req0_valid || req1_valid)) begin
            g = (req0_valid && req1_valid) ? !pref0 : req1_valid;
            pref0 = g;
            op = g ? req1_op : req0_op;
            l  = g ? req1_left : req0_left;
            r  = g ? req1_right : req0_right;
            res = ref_op(op, l, r);
            pend = 1; p_own = g; p_err = res[W]; p_res = res[W-1:0];
            rsp_due = k + 1; m_free = k + 2;
            e_l = l; e_r = r; e_c = res[W] ? 4'd0 : op;
        end
    end

    initial forever begin
        bit idle, v;
        @(negedge clk);
        if (model_ok) begin
            idle = (k >= m_free);
            v = pend && (k == rsp_due);
            chk("req0_ready", 32'(req0_ready), 32'(idle && req0_valid && (!req1_valid || pref0)));
            chk("req1_ready", 32'(req1_ready), 32'(idle && req1_valid && (!req0_valid || !pref0)));
            chk("busy", 32'(busy), 32'(!idle));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(v && !p_own));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(v && p_own));
            chk("rsp0_result", rsp0_result, (v && !p_own) ? p_res : 32'd0);
            chk("rsp1_result", rsp1_result, (v && p_own) ? p_res : 32'd0);
            chk("rsp0_err", 32'(rsp0_err), 32'(v && !p_own && p_err));
            chk("rsp1_err", 32'(rsp1_err), 32'(v && p_own && p_err));
            chk("alu_left", alu_left, e_l);
            chk("alu_right", alu_right, e_r);
            chk("alu_control", 32'(alu_control), 32'(e_c));
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    // Issue one request, then check the EXEC control value and the response literally.
    task automatic send(input int p, input logic [3:0] op, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] exp_res, input logic exp_err, input logic [3:0] exp_ctl);
        bit got = 0;
        if (p == 0) begin req0_op = op; req0_left = l; req0_right = r; req0_valid = 1'b1; end
        else        begin req1_op = op; req1_left = l; req1_right = r; req1_valid = 1'b1; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        chk("ready_seen", 32'(got), 32'd1);
        @(posedge clk); #2;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ctl", 32'(alu_control), 32'(exp_ctl));
        @(negedge clk);
        chk("lit_rsp_valid", 32'((p == 0) ? rsp0_valid : rsp1_valid), 32'd1);
        chk("lit_rsp_result", (p == 0) ? rsp0_result : rsp1_result, exp_res);
        chk("lit_rsp_err", 32'((p == 0) ? rsp0_err : rsp1_err), 32'(exp_err));
        @(posedge clk); #2;
    endtask

    initial begin
        int owners[$];
        int when[$];
        bit seen1;

        do_reset();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(posedge clk); #2;

        send(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 4'b0010);
        send(1, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'b0110);
        send(0, 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 4'b1100);
        send(0, 4'b0011, 32'd9, 32'd6, 32'd0, 1'b1, 4'b0000);
        send(0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0111);
        send(1, 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'b0111);
        send(1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 4'b0000);
        send(0, 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 4'b0001);
        send(1, 4'b1111, 32'd1, 32'd1, 32'd0, 1'b1, 4'b0000);

        // req1 raised only while busy, then withdrawn: never accepted
        req0_op = 4'b0010; req0_left = 32'd1; req0_right = 32'd1; req0_valid = 1'b1;
        @(posedge clk); #2 req0_valid = 1'b0;
        req1_op = 4'b0010; req1_left = 32'd100; req1_right = 32'd1; req1_valid = 1'b1;
        @(posedge clk); #2 req1_valid = 1'b0;
        seen1 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp1_valid) seen1 = 1;
        end
        chk("dropped_req1_no_rsp", 32'(seen1), 32'd0);
        @(posedge clk); #2;

        // contention after reset: grants alternate starting with req0
        do_reset();
        req0_op = 4'b0111; req0_left = 32'd1; req0_right = 32'd2;
        req1_op = 4'b0111; req1_left = 32'd4; req1_right = 32'd3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin owners.push_back(0); when.push_back(i); end
            if (rsp1_valid) begin owners.push_back(1); when.push_back(i); end
        end
        @(posedge clk); #2 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", 32'(owners.size()), 32'd4);
        if (owners.size() == 4) begin
            chk("rr_owner0", 32'(owners[0]), 32'd0);
            chk("rr_owner1", 32'(owners[1]), 32'd1);
            chk("rr_owner2", 32'(owners[2]), 32'd0);
            chk("rr_owner3", 32'(owners[3]), 32'd1);
            chk("rr_gap", 32'(when[3] - when[0]), 32'd9);
        end
        repeat (4) @(posedge clk);
        #2;

        // reset while EXEC: transaction dropped, no strobe
        req0_op = 4'b0010; req0_left = 32'd9; req0_right = 32'd1; req0_valid = 1'b1;
        @(negedge clk);
        chk("rexec_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #2 req0_valid = 1'b0; reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rexec_busy", 32'(busy), 32'd0);
        chk("rexec_alu_left", alu_left, 32'd0);
        chk("rexec_alu_control", 32'(alu_control), 32'd0);
        seen1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen1 = 1;
        end
        chk("rexec_no_rsp", 32'(seen1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
